// File: rtl/conv_window_addr_gen.sv
`default_nettype none
// ============================================================================
// Module   : conv_window_addr_gen
// Purpose  : Walks a channel-major input feature map held in activation SRAM
//            and emits one read address per kernel tap of every output
//            position (order oy, ox, c, ky, kx), through a valid/ready port.
//            Kernel size, stride, channel count and map size are runtime
//            configurable through a small indexed config port.
// Ports    : clk, rstn (sync, active-low)
//            cfg_we/cfg_sel/cfg_data : config write (0 in_ch, 1 in_w, 2 in_h,
//                                      3 k, 4 stride; 5-7 ignored)
//            start/busy/done         : layer walk control and status
//            addr_valid/addr_ready/addr/win_first/win_last : address stream
//            cfg_err                 : sticky invalid-config flag
// Revision : 1.0 - initial release
// ============================================================================
module conv_window_addr_gen #(
  parameter int          ADDR_W    = 16,
  parameter int          DIM_W     = 8,
  parameter int          K_W       = 4,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              cfg_we,
  input  logic [2:0]        cfg_sel,
  input  logic [DIM_W-1:0]  cfg_data,
  input  logic              start,
  output logic              busy,
  output logic              addr_valid,
  input  logic              addr_ready,
  output logic [ADDR_W-1:0] addr,
  output logic              win_first,
  output logic              win_last,
  output logic              done,
  output logic              cfg_err
);

  localparam logic [ADDR_W-1:0] C_BASE = ADDR_W'(BASE_ADDR);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state_q;

  // Configuration (writes are blocked while busy, so these are stable in a walk)
  logic [DIM_W-1:0]  in_ch_q, in_w_q, in_h_q;
  logic [K_W-1:0]    k_q, stride_q;

  // Values latched at start
  logic [DIM_W-1:0]  ow_last_q, oh_last_q;
  logic [ADDR_W-1:0] plane_q;      // in_w*in_h : distance between channels
  logic [ADDR_W-1:0] rstep_q;      // stride*in_w : distance between output rows

  // Position counters
  logic [DIM_W-1:0]  oy_q, ox_q, c_q;
  logic [K_W-1:0]    ky_q, kx_q;

  // Running address accumulators (adds only in the per-cycle path)
  logic [ADDR_W-1:0] row_base_q, win_base_q, ch_base_q, tap_row_q;

  // Registered outputs
  logic              busy_q, addr_valid_q, win_first_q, win_last_q, done_q, cfg_err_q;
  logic [ADDR_W-1:0] addr_q;

  // Next-position values applied on a transfer
  logic [DIM_W-1:0]  oy_d, ox_d, c_d;
  logic [K_W-1:0]    ky_d, kx_d;
  logic [ADDR_W-1:0] row_base_d, win_base_d, ch_base_d, tap_row_d, addr_d;
  logic              win_first_d, win_last_d, last_tap;

  logic [K_W-1:0]    k_last;
  logic [DIM_W-1:0]  ch_last;
  logic              cfg_ok;

  assign k_last  = k_q - 1'b1;
  assign ch_last = in_ch_q - 1'b1;
  assign cfg_ok  = (in_ch_q != '0) && (k_q != '0) && (stride_q != '0) &&
                   (DIM_W'(k_q) <= in_w_q) && (DIM_W'(k_q) <= in_h_q);

  always_comb begin
    oy_d       = oy_q;
    ox_d       = ox_q;
    c_d        = c_q;
    ky_d       = ky_q;
    kx_d       = kx_q;
    row_base_d = row_base_q;
    win_base_d = win_base_q;
    ch_base_d  = ch_base_q;
    tap_row_d  = tap_row_q;
    addr_d     = addr_q;
    last_tap   = 1'b0;
    if (kx_q != k_last) begin
      kx_d   = kx_q + 1'b1;
      addr_d = addr_q + 1'b1;
    end else if (ky_q != k_last) begin
      kx_d      = '0;
      ky_d      = ky_q + 1'b1;
      tap_row_d = tap_row_q + ADDR_W'(in_w_q);
      addr_d    = tap_row_d;
    end else if (c_q != ch_last) begin
      kx_d      = '0;
      ky_d      = '0;
      c_d       = c_q + 1'b1;
      ch_base_d = ch_base_q + plane_q;
      tap_row_d = ch_base_d;
      addr_d    = ch_base_d;
    end else if (ox_q != ow_last_q) begin
      kx_d       = '0;
      ky_d       = '0;
      c_d        = '0;
      ox_d       = ox_q + 1'b1;
      win_base_d = win_base_q + ADDR_W'(stride_q);
      ch_base_d  = win_base_d;
      tap_row_d  = win_base_d;
      addr_d     = win_base_d;
    end else if (oy_q != oh_last_q) begin
      kx_d       = '0;
      ky_d       = '0;
      c_d        = '0;
      ox_d       = '0;
      oy_d       = oy_q + 1'b1;
      row_base_d = row_base_q + rstep_q;
      win_base_d = row_base_d;
      ch_base_d  = row_base_d;
      tap_row_d  = row_base_d;
      addr_d     = row_base_d;
    end else begin
      last_tap = 1'b1;
    end
    win_first_d = (kx_d == '0) && (ky_d == '0) && (c_d == '0);
    win_last_d  = (kx_d == k_last) && (ky_d == k_last) && (c_d == ch_last);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q      <= S_IDLE;
      in_ch_q      <= DIM_W'(1);
      in_w_q       <= DIM_W'(1);
      in_h_q       <= DIM_W'(1);
      k_q          <= K_W'(1);
      stride_q     <= K_W'(1);
      ow_last_q    <= '0;
      oh_last_q    <= '0;
      plane_q      <= '0;
      rstep_q      <= '0;
      oy_q         <= '0;
      ox_q         <= '0;
      c_q          <= '0;
      ky_q         <= '0;
      kx_q         <= '0;
      row_base_q   <= '0;
      win_base_q   <= '0;
      ch_base_q    <= '0;
      tap_row_q    <= '0;
      busy_q       <= 1'b0;
      addr_valid_q <= 1'b0;
      addr_q       <= '0;
      win_first_q  <= 1'b0;
      win_last_q   <= 1'b0;
      done_q       <= 1'b0;
      cfg_err_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (cfg_we && !busy_q) begin
        case (cfg_sel)
          3'd0:    in_ch_q  <= cfg_data;
          3'd1:    in_w_q   <= cfg_data;
          3'd2:    in_h_q   <= cfg_data;
          3'd3:    k_q      <= cfg_data[K_W-1:0];
          3'd4:    stride_q <= cfg_data[K_W-1:0];
          default: ;
        endcase
      end
      case (state_q)
        S_IDLE: begin
          if (start) begin
            if (cfg_ok) begin
              state_q      <= S_RUN;
              busy_q       <= 1'b1;
              cfg_err_q    <= 1'b0;
              // (dim-k)/stride is the index of the last output position
              ow_last_q    <= (in_w_q - DIM_W'(k_q)) / DIM_W'(stride_q);
              oh_last_q    <= (in_h_q - DIM_W'(k_q)) / DIM_W'(stride_q);
              plane_q      <= ADDR_W'(in_w_q) * ADDR_W'(in_h_q);
              rstep_q      <= ADDR_W'(in_w_q) * ADDR_W'(stride_q);
              oy_q         <= '0;
              ox_q         <= '0;
              c_q          <= '0;
              ky_q         <= '0;
              kx_q         <= '0;
              row_base_q   <= C_BASE;
              win_base_q   <= C_BASE;
              ch_base_q    <= C_BASE;
              tap_row_q    <= C_BASE;
              addr_q       <= C_BASE;
              addr_valid_q <= 1'b1;
              win_first_q  <= 1'b1;
              win_last_q   <= (k_last == '0) && (ch_last == '0);
            end else begin
              cfg_err_q <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if (addr_valid_q && addr_ready) begin
            if (last_tap) begin
              state_q      <= S_DONE;
              addr_valid_q <= 1'b0;
              done_q       <= 1'b1;
            end else begin
              oy_q        <= oy_d;
              ox_q        <= ox_d;
              c_q         <= c_d;
              ky_q        <= ky_d;
              kx_q        <= kx_d;
              row_base_q  <= row_base_d;
              win_base_q  <= win_base_d;
              ch_base_q   <= ch_base_d;
              tap_row_q   <= tap_row_d;
              addr_q      <= addr_d;
              win_first_q <= win_first_d;
              win_last_q  <= win_last_d;
            end
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy       = busy_q;
  assign addr_valid = addr_valid_q;
  assign addr       = addr_q;
  assign win_first  = win_first_q;
  assign win_last   = win_last_q;
  assign done       = done_q;
  assign cfg_err    = cfg_err_q;

endmodule
`default_nettype wire

// File: tb/tb_conv_window_addr_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_conv_window_addr_gen
// Purpose  : Directed self-checking bench for conv_window_addr_gen. Inputs
//            are driven and outputs sampled on the falling clock edge.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_conv_window_addr_gen;

  localparam int ADDR_W = 16;
  localparam int DIM_W  = 8;
  localparam int K_W    = 4;

  logic              clk = 1'b0;
  logic              rstn, cfg_we, start, addr_ready;
  logic [2:0]        cfg_sel;
  logic [DIM_W-1:0]  cfg_data;
  logic              busy, addr_valid, win_first, win_last, done, cfg_err;
  logic [ADDR_W-1:0] addr;

  int n_cmp = 0;
  int n_err = 0;

  // Entries are {win_first, win_last, addr}
  logic [17:0] exp_q[$];
  logic [17:0] got_q[$];

  always #5 clk = ~clk;

  conv_window_addr_gen #(
    .ADDR_W(ADDR_W), .DIM_W(DIM_W), .K_W(K_W), .BASE_ADDR(0)
  ) dut (
    .clk(clk), .rstn(rstn),
    .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_data(cfg_data),
    .start(start), .busy(busy),
    .addr_valid(addr_valid), .addr_ready(addr_ready), .addr(addr),
    .win_first(win_first), .win_last(win_last),
    .done(done), .cfg_err(cfg_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference walk written directly from the address formula
  task automatic build_exp(input int ch, input int w, input int h, input int k, input int s);
    int ow, oh, a;
    logic [15:0] a16;
    exp_q.delete();
    ow = (w - k) / s + 1;
    oh = (h - k) / s + 1;
    for (int oy = 0; oy < oh; oy++)
      for (int ox = 0; ox < ow; ox++)
        for (int c = 0; c < ch; c++)
          for (int ky = 0; ky < k; ky++)
            for (int kx = 0; kx < k; kx++) begin
              a   = c*w*h + (oy*s + ky)*w + ox*s + kx;
              a16 = a[15:0];
              exp_q.push_back({(c == 0 && ky == 0 && kx == 0),
                               (c == ch-1 && ky == k-1 && kx == k-1), a16});
            end
  endtask

  task automatic cfg_write(input logic [2:0] sel, input logic [DIM_W-1:0] d);
    cfg_we = 1'b1; cfg_sel = sel; cfg_data = d;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic setup(input int ch, input int w, input int h, input int k, input int s);
    cfg_write(3'd0, DIM_W'(ch));
    cfg_write(3'd1, DIM_W'(w));
    cfg_write(3'd2, DIM_W'(h));
    cfg_write(3'd3, DIM_W'(k));
    cfg_write(3'd4, DIM_W'(s));
  endtask

  // Start a walk and check every transfer against exp_q; optional stalls
  // (ready 1,0,0 repeating) and an ignored start pulse mid-walk.
  task automatic walk(input string tag, input bit stall, input bit mid_start);
    int idx = 0;
    int cyc = 0;
    bit held = 1'b0;
    logic [17:0] held_v = '0;
    got_q.delete();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({tag, "_busy"},  32'(busy), 32'd1);
    check({tag, "_valid"}, 32'(addr_valid), 32'd1);
    check({tag, "_err"},   32'(cfg_err), 32'd0);
    while (idx < exp_q.size() && cyc < 400) begin
      if (held)
        check({tag, "_hold"}, 32'({addr_valid, win_first, win_last, addr}), 32'({1'b1, held_v}));
      addr_ready = stall ? (cyc % 3 == 0) : 1'b1;
      start      = mid_start && (cyc == 4);
      if (addr_valid && addr_ready) begin
        got_q.push_back({win_first, win_last, addr});
        check({tag, "_tap"}, 32'({win_first, win_last, addr}), 32'(exp_q[idx]));
        idx++;
        held = 1'b0;
      end else begin
        held   = addr_valid;
        held_v = {win_first, win_last, addr};
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    check({tag, "_count"},     32'(idx), 32'(exp_q.size()));
    check({tag, "_done"},      32'(done), 32'd1);
    check({tag, "_valid_end"}, 32'(addr_valid), 32'd0);
    check({tag, "_busy_done"}, 32'(busy), 32'd1);
    addr_ready = 1'b0;
    @(negedge clk);
    check({tag, "_done_off"}, 32'(done), 32'd0);
    check({tag, "_idle"},     32'(busy), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] w0 [9];
    logic [15:0] w3 [9];
    int n_last;
    int cnt;
    w0 = '{16'd0, 16'd1, 16'd2, 16'd4, 16'd5, 16'd6, 16'd8, 16'd9, 16'd10};
    w3 = '{16'd12, 16'd13, 16'd14, 16'd17, 16'd18, 16'd19, 16'd22, 16'd23, 16'd24};

    rstn = 1'b0; cfg_we = 1'b0; cfg_sel = '0; cfg_data = '0;
    start = 1'b0; addr_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy",  32'(busy), 32'd0);
    check("rst_valid", 32'(addr_valid), 32'd0);
    check("rst_addr",  32'(addr), 32'd0);
    check("rst_flags", 32'({win_first, win_last, done, cfg_err}), 32'd0);
    rstn = 1'b1;
    @(negedge clk);

    // 4x4 map, 3x3 kernel, stride 1
    setup(1, 4, 4, 3, 1);
    build_exp(1, 4, 4, 3, 1);
    walk("t1", 1'b0, 1'b0);
    for (int i = 0; i < 9; i++) check("t1_win0", 32'(got_q[i][15:0]), 32'(w0[i]));
    check("t1_win1_first", 32'(got_q[9]),  32'({2'b10, 16'd1}));
    check("t1_first18",    32'(got_q[18][17]), 32'd1);
    check("t1_first27",    32'(got_q[27]), 32'({2'b10, 16'd5}));
    check("t1_final",      32'(got_q[35]), 32'({2'b01, 16'd15}));

    // 5x5 map, 3x3 kernel, stride 2
    setup(1, 5, 5, 3, 2);
    build_exp(1, 5, 5, 3, 2);
    walk("t2", 1'b0, 1'b0);
    check("t2_w0", 32'(got_q[0]),  32'({2'b10, 16'd0}));
    check("t2_w1", 32'(got_q[9]),  32'({2'b10, 16'd2}));
    check("t2_w2", 32'(got_q[18]), 32'({2'b10, 16'd10}));
    for (int i = 0; i < 9; i++) check("t2_win3", 32'(got_q[27+i][15:0]), 32'(w3[i]));

    // Two channels, single 3x3 window
    setup(2, 3, 3, 3, 1);
    build_exp(2, 3, 3, 3, 1);
    walk("t3", 1'b0, 1'b0);
    n_last = 0;
    for (int i = 0; i < 18; i++) begin
      check("t3_seq", 32'(got_q[i][15:0]), i);
      n_last += int'(got_q[i][16]);
    end
    check("t3_nlast",  n_last, 1);
    check("t3_last17", 32'(got_q[17][16]), 32'd1);
    check("t3_first9", 32'(got_q[9][17]), 32'd0);

    // First config again under backpressure
    setup(1, 4, 4, 3, 1);
    build_exp(1, 4, 4, 3, 1);
    walk("t4", 1'b1, 1'b0);

    // Invalid config: k=5 exceeds in_w=4
    setup(1, 4, 4, 5, 1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("t5_err",   32'(cfg_err), 32'd1);
    check("t5_busy",  32'(busy), 32'd0);
    check("t5_valid", 32'(addr_valid), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t5_quiet", 32'({addr_valid, busy, cfg_err}), 32'b001);
    end
    cfg_write(3'd3, DIM_W'(3));
    walk("t5", 1'b0, 1'b1);

    // Reset after the 10th transfer
    setup(1, 4, 4, 3, 1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    addr_ready = 1'b1;
    cnt = 0;
    for (int i = 0; i < 100 && cnt < 10; i++) begin
      if (addr_valid && addr_ready) cnt++;
      @(negedge clk);
    end
    check("t6_xfers", cnt, 10);
    rstn = 1'b0;
    @(negedge clk);
    check("t6_valid", 32'(addr_valid), 32'd0);
    check("t6_busy",  32'(busy), 32'd0);
    check("t6_outs",  32'({addr, win_first, win_last, done, cfg_err}), 32'd0);
    rstn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t6_nodone", 32'({done, addr_valid, busy}), 32'd0);
    end
    build_exp(1, 1, 1, 1, 1);
    walk("t6", 1'b0, 1'b0);
    check("t6_default_tap", 32'(got_q[0]), 32'({2'b11, 16'd0}));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
